decoder3to8_pulse: RTL and testbench

Registered 3-to-8 one-hot decoder with pulse stretching. It is the receive-side counterpart of the team's 8-to-3 encoder. A 3-bit code arrives over a valid/ready handshake, and the block drives the matching one-hot line high for a programmable number of cycles. It then inserts a programmable all-zero guard gap before it accepts the next code. It sits between code producers (encoder outputs, control FSMs) and strobe-driven downstream logic that needs clean, non-overlapping select pulses.

---
 rtl/decoder_pkg.sv | 12 +
 rtl/onehot3to8.sv | 12 +
 rtl/decoder3to8_pulse.sv | 108 ++++++++++
 tb/tb_decoder3to8_pulse.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/decoder_pkg.sv
// Shared types and constants for the pulse-stretching 3-to-8 decoder.
package decoder_pkg;

   localparam int unsigned CNT_W = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      DRIVE = 2'b01,
      GAP   = 2'b10
   } state_e;

endpackage

// File: rtl/onehot3to8.sv
// Purely combinational 3-bit code to 8-bit one-hot decoder.
module onehot3to8 (
   input  logic [2:0] code,
   output logic [7:0] onehot
);

   always_comb begin
      onehot       = '0;
      onehot[code] = 1'b1;
   end

endmodule

// File: rtl/decoder3to8_pulse.sv
// Registered 3-to-8 one-hot decoder: each accepted code drives its line for
// PULSE_LEN cycles, followed by GAP_LEN all-zero cycles before the next accept.
module decoder3to8_pulse
   import decoder_pkg::*;
#(
   parameter int unsigned PULSE_LEN = 4,
   parameter int unsigned GAP_LEN   = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       En,
   input  logic [2:0] Din,
   input  logic       Din_valid,
   output logic       Din_ready,
   output logic [7:0] D0,
   output logic       busy,
   output logic       done,
   output logic       err
);

   localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_LEN - 1);
   localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'((GAP_LEN == 0) ? 0 : GAP_LEN - 1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [7:0]       d0_q, d0_d;
   logic             done_q, done_d;
   logic             err_q, err_d;
   logic [7:0]       onehot;

   onehot3to8 u_onehot (
      .code   (Din),
      .onehot (onehot)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      d0_d    = d0_q;
      done_d  = 1'b0;
      err_d   = Din_valid && !En;

      if (!En) begin
         // Abort: drop the line at once and suppress done for this pulse.
         state_d = IDLE;
         d0_d    = '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (Din_valid) begin
                  d0_d    = onehot;
                  cnt_d   = PULSE_LOAD;
                  state_d = DRIVE;
               end
            end
            DRIVE: begin
               if (cnt_q == '0) begin
                  d0_d   = '0;
                  done_d = 1'b1;
                  if (GAP_LEN > 0) begin
                     state_d = GAP;
                     cnt_d   = GAP_LOAD;
                  end else begin
                     state_d = IDLE;
                  end
               end else begin
                  cnt_d = cnt_q - 1'b1;
               end
            end
            GAP: begin
               d0_d = '0;
               if (cnt_q == '0) begin
                  state_d = IDLE;
               end else begin
                  cnt_d = cnt_q - 1'b1;
               end
            end
            default: begin
               state_d = IDLE;
               d0_d    = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         d0_q    <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         d0_q    <= d0_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   assign Din_ready = (state_q == IDLE) && En;
   assign busy      = (state_q != IDLE);
   assign D0        = d0_q;
   assign done      = done_q;
   assign err       = err_q;

endmodule

// File: tb/tb_decoder3to8_pulse.sv
// Bench for decoder3to8_pulse: two instances (4/1 and 3/0 timing) share stimulus,
// each checked every cycle against a pulse-age timeline model plus directed literals.
module tb_decoder3to8_pulse;

   localparam int unsigned PA = 4, GA = 1;
   localparam int unsigned PB = 3, GB = 0;

   logic       clk = 1'b0;
   logic       rst, en, vld;
   logic [2:0] din;
   logic [7:0] d0    [2];
   logic       ready [2];
   logic       busy  [2];
   logic       done  [2];
   logic       err   [2];

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   decoder3to8_pulse #(.PULSE_LEN(PA), .GAP_LEN(GA)) dut_a (
      .clk(clk), .rst(rst), .En(en), .Din(din), .Din_valid(vld),
      .Din_ready(ready[0]), .D0(d0[0]), .busy(busy[0]), .done(done[0]), .err(err[0])
   );

   decoder3to8_pulse #(.PULSE_LEN(PB), .GAP_LEN(GB)) dut_b (
      .clk(clk), .rst(rst), .En(en), .Din(din), .Din_valid(vld),
      .Din_ready(ready[1]), .D0(d0[1]), .busy(busy[1]), .done(done[1]), .err(err[1])
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Model: a pulse is described only by its age in cycles since accept.
   bit         m_act  [2];
   int         m_age  [2];
   logic [2:0] m_code [2];
   bit         m_done [2];
   bit         m_err  [2];

   function automatic int unsigned plen(input int i);
      return (i == 0) ? PA : PB;
   endfunction

   function automatic int unsigned glen(input int i);
      return (i == 0) ? GA : GB;
   endfunction

   always @(posedge clk or posedge rst) begin
      for (int i = 0; i < 2; i++) begin
         if (rst) begin
            m_act[i]  = 1'b0;
            m_age[i]  = 0;
            m_code[i] = '0;
            m_done[i] = 1'b0;
            m_err[i]  = 1'b0;
         end else begin
            m_err[i]  = vld && !en;
            m_done[i] = 1'b0;
            if (!en) begin
               m_act[i] = 1'b0;
            end else if (m_act[i]) begin
               m_age[i]++;
               if (m_age[i] == int'(plen(i)) + 1) m_done[i] = 1'b1;
               if (m_age[i] > int'(plen(i) + glen(i))) m_act[i] = 1'b0;
            end else if (vld) begin
               m_act[i]  = 1'b1;
               m_age[i]  = 1;
               m_code[i] = din;
            end
         end
      end
   end

   bit         rec = 1'b0;
   logic [7:0] rec_q[$];

   always @(negedge clk) begin
      if (!rst) begin
         for (int i = 0; i < 2; i++) begin
            logic [7:0] exp_d0;
            exp_d0 = (m_act[i] && m_age[i] <= int'(plen(i))) ? (8'(1) << m_code[i]) : 8'h00;
            check($sformatf("d0[%0d]", i), 32'(d0[i]), 32'(exp_d0));
            check($sformatf("busy[%0d]", i), 32'(busy[i]), 32'(m_act[i]));
            check($sformatf("ready[%0d]", i), 32'(ready[i]), 32'(!m_act[i] && en));
            check($sformatf("done[%0d]", i), 32'(done[i]), 32'(m_done[i]));
            check($sformatf("err[%0d]", i), 32'(err[i]), 32'(m_err[i]));
            check($sformatf("onehot[%0d]", i), 32'($countones(d0[i]) <= 1), 32'd1);
         end
         if (rec) rec_q.push_back(d0[1]);
      end
   end

   task automatic idle_wait(input int n);
      vld = 1'b0;
      for (int k = 0; k < n; k++) tick();
   endtask

   initial begin
      logic [7:0] exp_seq[$];
      bit         ok;

      rst = 1'b1; en = 1'b0; vld = 1'b0; din = '0;
      #3;
      check("rst_d0", 32'(d0[0]), 32'h00);
      check("rst_busy", 32'(busy[0]), 32'd0);
      check("rst_done", 32'(done[0]), 32'd0);
      check("rst_err", 32'(err[0]), 32'd0);
      tick();
      en = 1'b1;
      #1;
      check("rst_ready_en", 32'(ready[0]), 32'd1);
      tick();
      rst = 1'b0;
      tick();

      // Single code 5 on the 4/1 instance.
      vld = 1'b1; din = 3'd5;
      check("single_ready_T", 32'(ready[0]), 32'd1);
      tick();
      vld = 1'b0;
      check("single_d0_T1", 32'(d0[0]), 32'h20);
      check("single_busy_T1", 32'(busy[0]), 32'd1);
      tick(); tick(); tick();
      check("single_d0_T4", 32'(d0[0]), 32'h20);
      tick();
      check("single_d0_T5", 32'(d0[0]), 32'h00);
      check("single_done_T5", 32'(done[0]), 32'd1);
      check("single_ready_T5", 32'(ready[0]), 32'd0);
      tick();
      check("single_ready_T6", 32'(ready[0]), 32'd1);
      check("single_done_T6", 32'(done[0]), 32'd0);
      idle_wait(6);

      // Async reset mid-pulse.
      vld = 1'b1; din = 3'd5;
      tick();
      vld = 1'b0;
      check("midrst_pre_d0", 32'(d0[0]), 32'h20);
      #2 rst = 1'b1;
      #1;
      check("midrst_d0", 32'(d0[0]), 32'h00);
      check("midrst_busy", 32'(busy[0]), 32'd0);
      check("midrst_done", 32'(done[0]), 32'd0);
      tick();
      rst = 1'b0;
      #1;
      check("midrst_ready", 32'(ready[0]), 32'd1);
      idle_wait(6);

      // Back-to-back sweep on the 3/0 instance.
      rec = 1'b1;
      for (int k = 0; k < 8; k++) begin
         din = 3'(k); vld = 1'b1;
         ok = 1'b0;
         for (int w = 0; w < 20 && !ok; w++) begin
            if (ready[1]) ok = 1'b1;
            tick();
         end
         if (!ok) check("sweep_timeout", 32'd0, 32'd1);
      end
      vld = 1'b0;
      tick(); tick(); tick(); tick();
      rec = 1'b0;
      exp_seq.push_back(8'h00);
      for (int k = 0; k < 8; k++) begin
         for (int r = 0; r < int'(PB); r++) exp_seq.push_back(8'(1) << k);
         exp_seq.push_back(8'h00);
      end
      check("sweep_len_ok", 32'(rec_q.size() >= exp_seq.size()), 32'd1);
      for (int j = 0; j < exp_seq.size() && j < rec_q.size(); j++)
         check($sformatf("sweep[%0d]", j), 32'(rec_q[j]), 32'(exp_seq[j]));
      idle_wait(8);

      // Back-pressure on the 4/1 instance.
      vld = 1'b1; din = 3'd2;
      tick();
      din = 3'd3;
      check("bp_ready_T1", 32'(ready[0]), 32'd0);
      check("bp_d0_T1", 32'(d0[0]), 32'h04);
      tick(); tick(); tick(); tick(); tick();
      check("bp_ready_T6", 32'(ready[0]), 32'd1);
      check("bp_d0_T6", 32'(d0[0]), 32'h00);
      tick();
      vld = 1'b0;
      check("bp_d0_T7", 32'(d0[0]), 32'h08);
      idle_wait(8);

      // Abort of a code-6 pulse, with valid offered while disabled.
      vld = 1'b1; din = 3'd6;
      tick();
      vld = 1'b0;
      check("abort_d0_T1", 32'(d0[0]), 32'h40);
      tick();
      en = 1'b0; vld = 1'b1;
      tick();
      check("abort_d0_T3", 32'(d0[0]), 32'h00);
      check("abort_busy_T3", 32'(busy[0]), 32'd0);
      check("abort_done_T3", 32'(done[0]), 32'd0);
      check("abort_err_T3", 32'(err[0]), 32'd1);
      tick();
      vld = 1'b0;
      check("abort_err_T4", 32'(err[0]), 32'd1);
      check("abort_done_T4", 32'(done[0]), 32'd0);
      tick();
      check("abort_err_T5", 32'(err[0]), 32'd0);
      en = 1'b1;
      idle_wait(4);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

endmodule
